// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - byte-addressable data memory controller with request/response handshake
// Optional feature macro: DMEM_UNALIGNED_EN (two-row misaligned accesses).
module dmem_ctrl #(
  parameter int MEM_BYTES = 128,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int ROWS  = MEM_BYTES / 4;
  localparam int IDX_W = $clog2(ROWS);
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(MEM_BYTES);

  typedef enum logic [1:0] {IDLE, ACCESS, ACCESS2, RESP} state_t;

  state_t            state;
  logic              wr_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       lo_q;

  logic [31:0] mem [ROWS];

  logic [2:0]       nbytes;
  logic [3:0]       base_be;
  logic [7:0]       be;
  logic [1:0]       off;
  logic [ADDR_W:0]  end_addr;
  logic             range_err;
  logic             align_err;
  logic             span;
  logic             err;
  logic [IDX_W-1:0] row_lo;
  logic [IDX_W-1:0] row_hi;
  logic [63:0]      wwin;
  logic [63:0]      rwin;
  logic [31:0]      load_raw;
  logic [31:0]      load_ext;
  logic             we_lo;
  logic             we_hi;

  assign req_ready = rst_n && (state == IDLE);

  always_comb begin
    nbytes  = 3'd4;
    base_be = 4'b1111;
    case (size_q)
      2'b00: begin nbytes = 3'd1; base_be = 4'b0001; end
      2'b01: begin nbytes = 3'd2; base_be = 4'b0011; end
      default: begin nbytes = 3'd4; base_be = 4'b1111; end
    endcase
  end

  assign off       = addr_q[1:0];
  // Full-width sum so that large or wrapping addresses can never alias into range.
  assign end_addr  = {1'b0, addr_q} + {{(ADDR_W-2){1'b0}}, nbytes};
  assign range_err = end_addr > LIMIT;

`ifdef DMEM_UNALIGNED_EN
  assign align_err = 1'b0;
  assign span      = ({1'b0, off} + nbytes) > 3'd4;
`else
  assign align_err = (size_q == 2'b01 && off[0]) || (size_q == 2'b10 && off != 2'b00);
  assign span      = 1'b0;
`endif

  assign err    = (size_q == 2'b11) || range_err || align_err;
  assign row_lo = addr_q[IDX_W+1:2];
  assign row_hi = row_lo + IDX_W'(1);

  // A 64-bit window over two adjacent rows: lanes 0-3 lower row, 4-7 upper row.
  assign be   = {4'b0000, base_be} << off;
  assign wwin = {32'h0, wdata_q} << {off, 3'b000};
  assign rwin = (state == ACCESS2) ? {mem[row_hi], lo_q} : {32'h0, mem[row_lo]};
  assign load_raw = 32'(rwin >> {off, 3'b000});

  always_comb begin
    load_ext = load_raw;
    case (size_q)
      2'b00: load_ext = uns_q ? {24'h0, load_raw[7:0]}  : {{24{load_raw[7]}}, load_raw[7:0]};
      2'b01: load_ext = uns_q ? {16'h0, load_raw[15:0]} : {{16{load_raw[15]}}, load_raw[15:0]};
      default: load_ext = load_raw;
    endcase
  end

  assign we_lo = (state == ACCESS) && wr_q && !err;
  assign we_hi = (state == ACCESS2) && wr_q;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we_lo && be[i])   mem[row_lo][8*i +: 8] <= wwin[8*i +: 8];
      if (we_hi && be[4+i]) mem[row_hi][8*i +: 8] <= wwin[32+8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
      wr_q      <= 1'b0;
      size_q    <= 2'b00;
      uns_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= 32'h0;
      lo_q      <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            wr_q    <= req_write;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          if (err) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= 32'h0;
            state     <= RESP;
          end else if (span) begin
            lo_q  <= mem[row_lo];
            state <= ACCESS2;
          end else begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= wr_q ? 32'h0 : load_ext;
            state     <= RESP;
          end
        end
        ACCESS2: begin
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= wr_q ? 32'h0 : load_ext;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 SHALL provide parameter MEM_BYTES, default 128, storage size in bytes (power of two, >= 8).
REQ-002 SHALL provide parameter ADDR_W, default 32, request address width.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port req_valid  in  1  request present.
REQ-006 SHALL have port req_ready  out  1  block idle, can accept a request.
REQ-007 SHALL have port req_write  in  1  1 = store, 0 = load.
REQ-008 SHALL have port req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-009 SHALL have port req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
REQ-010 SHALL have port req_addr  in  ADDR_W  byte address.
REQ-011 SHALL have port req_wdata  in  32  store data, low bytes used for byte/half.
REQ-012 SHALL have port rsp_valid  out  1  response present.
REQ-013 SHALL have port rsp_ready  in  1  consumer accepts response.
REQ-014 SHALL have port rsp_rdata  out  32  extended load data; 0 for stores and errors.
REQ-015 SHALL have port rsp_err  out  1  access rejected, memory untouched.

Function
REQ-016 Storage SHALL be MEM_BYTES/4 rows of 32-bit words with byte-lane write enables, little-endian (byte addr+0 = bits 7:0).
REQ-017 FSM states SHALL be IDLE, ACCESS, ACCESS2, RESP; req_ready = 1 only in IDLE with rst_n high.
REQ-018 Request accepted on an edge with req_valid && req_ready; all req_* fields captured in that edge; IDLE -> ACCESS.
REQ-019 ACCESS edge SHALL perform the row write or capture read data; single-row access -> RESP, so rsp_valid rises on the first edge after acceptance.
REQ-020 RESP SHALL hold rsp_valid, rsp_rdata, rsp_err stable until an edge with rsp_ready = 1, then -> IDLE; rsp_valid low in that next cycle.
REQ-021 Error SHALL be raised when req_size = 11, or addr + bytes > MEM_BYTES, or (macro absent) addr not size-aligned; errored access: no write, rsp_rdata = 0, rsp_err = 1, still via ACCESS -> RESP.
REQ-022 Range check SHALL use full ADDR_W address without truncation; high address bits nonzero -> error.
REQ-023 Byte load SHALL extend bit 7, half load bit 15, per req_unsigned; word load unaffected by req_unsigned.
REQ-024 Store SHALL modify only the addressed bytes; neighbouring bytes unchanged.
REQ-025 rsp_err = 0 and rsp_rdata = 0 on successful stores.
REQ-026 req_valid changes while not in IDLE SHALL be ignored; rsp_ready outside RESP ignored.

Reset
REQ-027 rst_n low SHALL immediately force state IDLE, req_ready 0, rsp_valid 0, rsp_rdata 0, rsp_err 0.
REQ-028 Storage SHALL not be reset; simulation initial contents all zero.
REQ-029 Reset during ACCESS SHALL drop the request; a row already written at an earlier edge is not rolled back.

Configuration
REQ-030 Macro DMEM_UNALIGNED_EN absent: misaligned half/word -> error per REQ-021.
REQ-031 DMEM_UNALIGNED_EN defined: misaligned in-range access spanning two rows SHALL go ACCESS (lower row) -> ACCESS2 (upper row) -> RESP, rsp_valid one edge later than aligned; misaligned within one row stays single-cycle.
REQ-032 With macro, a spanning store SHALL write lower row at ACCESS edge, upper row at ACCESS2 edge; spanning load SHALL merge both rows before extension.

Verification
REQ-033 Store word 0xCAFEFACE to 0x08, load word 0x08 -> rsp_rdata 0xCAFEFACE, rsp_err 0; rsp_valid one edge after accept.
REQ-034 After REQ-033, store byte 0x7F to 0x09, load byte signed 0x0A -> 0xFFFFFFFE; load half unsigned 0x08 -> 0x00007FCE.
REQ-035 Load word at 0x7C -> ok; load word at 0x7E (macro absent) -> rsp_err 1, rdata 0; load at 0x80 -> rsp_err 1; req_size 11 -> rsp_err 1.
REQ-036 Hold rsp_ready 0 for 5 cycles in RESP -> rsp_valid, rdata stable, req_ready 0; new req_valid ignored.
REQ-037 Macro defined: store word 0x11223344 to 0x06, load word 0x06 -> 0x11223344, two edges accept-to-rsp_valid; word at 0x04 -> 0x33440000.
REQ-038 Assert rst_n low during ACCESS of a store to 0x10 -> rsp_valid 0 at once, word 0x10 unchanged, req_ready 1 after release.
